// File: rtl/rr_arb_mux_4_pkg.sv
// rtl/rr_arb_mux_4_pkg.sv - shared types and constants for the 4-port round-robin arbiter
package rr_arb_pkg;

  localparam int N_PORTS = 4;

  typedef logic [1:0] port_idx_t;

  typedef enum logic {
    ARB_IDLE,
    ARB_LOCKED
  } arb_state_t;

endpackage

// File: rtl/rr_arb_mux_4_if.sv
// rtl/rr_arb_mux_4_if.sv - stream bus between four sources, the arbiter and one sink
interface rr_arb_mux_4_if #(
  parameter int W = 4
);

  logic [3:0]   in_valid;
  logic [W-1:0] in_data0;
  logic [W-1:0] in_data1;
  logic [W-1:0] in_data2;
  logic [W-1:0] in_data3;
  logic [3:0]   in_last;
  logic [3:0]   in_ready;
  logic         out_valid;
  logic [W-1:0] out_data;
  logic [1:0]   out_sel;
  logic         out_ready;

  // Arbiter side
  modport slave (
    input  in_valid, in_data0, in_data1, in_data2, in_data3, in_last, out_ready,
    output in_ready, out_valid, out_data, out_sel
  );

  // Sources/sink side
  modport master (
    output in_valid, in_data0, in_data1, in_data2, in_data3, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_sel
  );

endinterface

// File: rtl/rr_arb_mux_4_grant.sv
// rtl/rr_arb_mux_4_grant.sv - combinational round-robin grant for four requesters
module rr_grant_4
  import rr_arb_pkg::*;
(
  input  logic [3:0] i_req,
  input  port_idx_t  i_ptr,
  output logic [3:0] o_grant,
  output port_idx_t  o_gidx,
  output logic       o_any
);

  // Scan ptr+1, ptr+2, ptr+3, ptr (2-bit wrap) and grant the first requester found
  always_comb begin
    port_idx_t v_idx;
    o_grant = 4'b0000;
    o_gidx  = '0;
    o_any   = 1'b0;
    for (int k = 1; k <= N_PORTS; k++) begin
      v_idx = i_ptr + port_idx_t'(k);
      if (!o_any && i_req[v_idx]) begin
        o_any          = 1'b1;
        o_gidx         = v_idx;
        o_grant[v_idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rr_arb_mux_4.sv
// rtl/rr_arb_mux_4.sv - round-robin 4:1 stream arbiter with registered output (optional burst lock: ARB_BURST_LOCK_EN)
module rr_arb_mux_4 #(
  parameter int W = 4
) (
  input logic         clk,
  input logic         rst,
  rr_arb_mux_4_if.slave bus
);

  import rr_arb_pkg::*;

  port_idx_t    r_ptr;
  logic         r_out_valid;
  logic [W-1:0] r_out_data;
  port_idx_t    r_out_sel;

  logic [3:0]   w_req;
  logic [3:0]   w_grant;
  port_idx_t    w_gidx;
  logic         w_any;
  logic         w_can_load;
  logic [3:0]   w_in_ready;
  logic         w_load;
  logic         w_ptr_adv;
  logic [W-1:0] w_sel_data;

`ifdef ARB_BURST_LOCK_EN
  arb_state_t r_state;
  arb_state_t w_state_nxt;
  port_idx_t  r_lock_idx;

  // While locked only the burst owner may request
  always_comb begin
    w_req = bus.in_valid;
    if (r_state == ARB_LOCKED) begin
      w_req = bus.in_valid & (4'b0001 << r_lock_idx);
    end
  end

  // Lock FSM next state; pointer stays put for the body of a burst
  always_comb begin
    w_state_nxt = r_state;
    w_ptr_adv   = w_load;
    case (r_state)
      ARB_IDLE: begin
        if (w_load && !bus.in_last[w_gidx]) begin
          w_state_nxt = ARB_LOCKED;
        end
      end
      ARB_LOCKED: begin
        w_ptr_adv = w_load && bus.in_last[r_lock_idx];
        if (w_ptr_adv) begin
          w_state_nxt = ARB_IDLE;
        end
      end
      default: w_state_nxt = ARB_IDLE;
    endcase
  end

  // Lock FSM state register; owner captured when a burst starts
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ARB_IDLE;
      r_lock_idx <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == ARB_IDLE && w_load) begin
        r_lock_idx <= w_gidx;
      end
    end
  end
`else
  assign w_req     = bus.in_valid;
  assign w_ptr_adv = w_load;
`endif

  rr_grant_4 u_grant (
    .i_req   (w_req),
    .i_ptr   (r_ptr),
    .o_grant (w_grant),
    .o_gidx  (w_gidx),
    .o_any   (w_any)
  );

  // Accept only when the output stage is empty or draining, never during reset
  assign w_can_load = ~r_out_valid | bus.out_ready;
  assign w_in_ready = w_grant & {4{w_can_load & ~rst & w_any}};
  assign w_load     = |w_in_ready;

  // 4:1 data select driven by the granted index
  always_comb begin
    w_sel_data = bus.in_data0;
    case (w_gidx)
      2'd0: w_sel_data = bus.in_data0;
      2'd1: w_sel_data = bus.in_data1;
      2'd2: w_sel_data = bus.in_data2;
      2'd3: w_sel_data = bus.in_data3;
      default: w_sel_data = bus.in_data0;
    endcase
  end

  // Output stage and last-grant pointer
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_sel   <= '0;
      r_ptr       <= 2'd3;
    end else begin
      if (w_load) begin
        r_out_valid <= 1'b1;
        r_out_data  <= w_sel_data;
        r_out_sel   <= w_gidx;
      end else if (bus.out_ready) begin
        r_out_valid <= 1'b0;
      end
      if (w_ptr_adv) begin
        r_ptr <= w_gidx;
      end
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.out_data  = r_out_data;
  assign bus.out_sel   = r_out_sel;

endmodule

// File: tb/tb_rr_arb_mux_4.sv
// tb/tb_rr_arb_mux_4.sv - directed self-checking bench for rr_arb_mux_4
module tb_rr_arb_mux_4;

  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;

  rr_arb_mux_4_if #(.W(4)) bus ();

  rr_arb_mux_4 #(.W(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    logic [3:0] exp_sel5 [4];
    logic [3:0] exp_dat5 [4];
    logic [3:0] last1 [4];
    logic [3:0] data1 [4];
    logic [3:0] seq1 [5];
    logic [3:0] dat1 [5];

    n_tests = 0;
    n_fail  = 0;

    // Reset with all ports requesting: nothing accepted during reset
    rst = 1'b1;
    bus.in_valid  = 4'b1111;
    bus.in_last   = 4'b1111;
    bus.in_data0  = 4'ha;
    bus.in_data1  = 4'hb;
    bus.in_data2  = 4'hc;
    bus.in_data3  = 4'hd;
    bus.out_ready = 1'b1;
    @(negedge clk);
    settle();
    chk("rst_in_ready", 32'(bus.in_ready), 32'h0);
    tick();
    chk("rst_out_valid", 32'(bus.out_valid), 32'h0);
    chk("rst_out_data", 32'(bus.out_data), 32'h0);
    chk("rst_out_sel", 32'(bus.out_sel), 32'h0);

    // 1: all valid, ready downstream -> 0,1,2,3,0 one per cycle
    rst = 1'b0;
    seq1 = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd0};
    dat1 = '{4'ha, 4'hb, 4'hc, 4'hd, 4'ha};
    for (int k = 0; k < 5; k++) begin
      settle();
      chk("t1_in_ready", 32'(bus.in_ready), 32'(4'b0001 << seq1[k]));
      tick();
      chk("t1_out_valid", 32'(bus.out_valid), 32'h1);
      chk("t1_out_sel", 32'(bus.out_sel), 32'(seq1[k]));
      chk("t1_out_data", 32'(bus.out_data), 32'(dat1[k]));
    end

    // 3: stall for 3 cycles holding sel 0 / data a, then port 1 follows at once
    bus.out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      settle();
      chk("t3_stall_in_ready", 32'(bus.in_ready), 32'h0);
      tick();
      chk("t3_stall_valid", 32'(bus.out_valid), 32'h1);
      chk("t3_stall_sel", 32'(bus.out_sel), 32'h0);
      chk("t3_stall_data", 32'(bus.out_data), 32'ha);
    end
    bus.out_ready = 1'b1;
    settle();
    chk("t3_resume_in_ready", 32'(bus.in_ready), 32'h2);
    tick();
    chk("t3_resume_valid", 32'(bus.out_valid), 32'h1);
    chk("t3_resume_sel", 32'(bus.out_sel), 32'h1);
    chk("t3_resume_data", 32'(bus.out_data), 32'hb);

    // 4: ptr=1, ports 0 and 1 -> port 0 via wrap, then port 1
    bus.in_valid = 4'b0011;
    settle();
    chk("t4_wrap_in_ready", 32'(bus.in_ready), 32'h1);
    tick();
    chk("t4_wrap_sel", 32'(bus.out_sel), 32'h0);
    chk("t4_wrap_data", 32'(bus.out_data), 32'ha);
    settle();
    chk("t4_next_in_ready", 32'(bus.in_ready), 32'h2);
    tick();
    chk("t4_next_sel", 32'(bus.out_sel), 32'h1);
    chk("t4_next_data", 32'(bus.out_data), 32'hb);

    // 2: single requester port 2, other data X, served back to back
    bus.in_valid = 4'b0100;
    bus.in_data0 = 4'bxxxx;
    bus.in_data1 = 4'bxxxx;
    bus.in_data2 = 4'h7;
    bus.in_data3 = 4'bxxxx;
    for (int k = 0; k < 3; k++) begin
      settle();
      chk("t2_in_ready", 32'(bus.in_ready), 32'h4);
      tick();
      chk("t2_valid", 32'(bus.out_valid), 32'h1);
      chk("t2_sel", 32'(bus.out_sel), 32'h2);
      chk("t2_data", 32'(bus.out_data), 32'h7);
    end

    // Drain with no new request: valid drops, data/sel keep old value
    bus.in_valid = 4'b0000;
    settle();
    chk("drain_in_ready", 32'(bus.in_ready), 32'h0);
    tick();
    chk("drain_valid", 32'(bus.out_valid), 32'h0);
    chk("drain_sel", 32'(bus.out_sel), 32'h2);
    chk("drain_data", 32'(bus.out_data), 32'h7);

    // 5: ptr=2, port 1 burst (last 0,0,1,0) vs port 2 always valid
    bus.in_valid = 4'b0110;
    bus.in_data2 = 4'h9;
    last1 = '{1'b0, 1'b0, 1'b1, 1'b0};
    data1 = '{4'h1, 4'h2, 4'h3, 4'h4};
`ifdef ARB_BURST_LOCK_EN
    exp_sel5 = '{4'd1, 4'd1, 4'd1, 4'd2};
    exp_dat5 = '{4'h1, 4'h2, 4'h3, 4'h9};
`else
    exp_sel5 = '{4'd1, 4'd2, 4'd1, 4'd2};
    exp_dat5 = '{4'h1, 4'h9, 4'h3, 4'h9};
`endif
    for (int k = 0; k < 4; k++) begin
      bus.in_last   = {2'b11, last1[k][0], 1'b1};
      bus.in_data1  = data1[k];
      settle();
      chk("t5_in_ready", 32'(bus.in_ready), 32'(4'b0001 << exp_sel5[k]));
      tick();
      chk("t5_sel", 32'(bus.out_sel), 32'(exp_sel5[k]));
      chk("t5_data", 32'(bus.out_data), 32'(exp_dat5[k]));
    end

    // 6: reset while holding a word -> discarded, then port 0 first
    bus.in_valid  = 4'b1111;
    bus.in_last   = 4'b1111;
    bus.in_data0  = 4'ha;
    bus.in_data1  = 4'hb;
    bus.in_data2  = 4'hc;
    bus.in_data3  = 4'hd;
    chk("t6_pre_valid", 32'(bus.out_valid), 32'h1);
    rst = 1'b1;
    settle();
    chk("t6_rst_in_ready", 32'(bus.in_ready), 32'h0);
    tick();
    chk("t6_rst_valid", 32'(bus.out_valid), 32'h0);
    chk("t6_rst_sel", 32'(bus.out_sel), 32'h0);
    chk("t6_rst_data", 32'(bus.out_data), 32'h0);
    rst = 1'b0;
    settle();
    chk("t6_first_in_ready", 32'(bus.in_ready), 32'h1);
    tick();
    chk("t6_first_sel", 32'(bus.out_sel), 32'h0);
    chk("t6_first_data", 32'(bus.out_data), 32'ha);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
